// File: rtl/ext_display_scan_if.sv
// rtl/ext_display_scan_if.sv - datapath-to-display bundle for the OUT-port scanner
interface ext_display_scan_if #(
    parameter int DATA_W = 16,
    parameter int DIGITS = 8
);
    logic [DATA_W-1:0] ar;
    logic              out_en;
    logic              ce;
    logic              cnt_clr;
    logic [1:0]        mode;
    logic [7:0]        seg;
    logic [DIGITS-1:0] dig_sel;
    logic              page;

    modport master (
        output ar, out_en, ce, cnt_clr, mode,
        input  seg, dig_sel, page
    );

    modport slave (
        input  ar, out_en, ce, cnt_clr, mode,
        output seg, dig_sel, page
    );
endinterface

// File: rtl/ext_display_scan.sv
// rtl/ext_display_scan.sv - latches the OUT value and scans it or a cycle counter onto 7-seg digits
module ext_display_scan #(
    parameter int DATA_W   = 16,
    parameter int DIGITS   = 8,
    parameter int CNT_W    = 32,
    parameter int SCAN_DIV = 1024,
    parameter int PAGE_DIV = 1 << 24
) (
    input  logic              clock,
    input  logic              reset,
    ext_display_scan_if.slave bus
);
    localparam int VAL_NIB = DATA_W / 4;
    localparam int CNT_NIB = CNT_W / 4;
    localparam int SCAN_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int DIG_W   = $clog2(DIGITS);
    localparam int PAGE_W  = (PAGE_DIV > 1) ? $clog2(PAGE_DIV) : 1;
    localparam int VEXT_W  = 4 * DIGITS;
    localparam int CEXT_W  = 8 * DIGITS;

    typedef enum logic {PG_VALUE = 1'b0, PG_COUNT = 1'b1} page_e;

    logic [DATA_W-1:0] out_q, out_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [SCAN_W-1:0] scan_cnt_q, scan_cnt_d;
    logic [DIG_W-1:0]  digit_q, digit_d;
    logic [1:0]        mode_q, mode_d;
    logic [PAGE_W-1:0] page_cnt_q, page_cnt_d;
    page_e             page_q, page_d;
    logic [7:0]        seg_q, seg_d;
    logic [DIGITS-1:0] dig_sel_q, dig_sel_d;

    logic              slot_end;
    logic [VEXT_W-1:0] val_ext;
    logic [CEXT_W-1:0] cnt_ext;
    logic [3:0]        nib;
    logic              blank;
    logic              dp;
    int                msn;
    int                d_i;
    int                hi_i;

    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: hex7 = 7'h3F;
            4'h1: hex7 = 7'h06;
            4'h2: hex7 = 7'h5B;
            4'h3: hex7 = 7'h4F;
            4'h4: hex7 = 7'h66;
            4'h5: hex7 = 7'h6D;
            4'h6: hex7 = 7'h7D;
            4'h7: hex7 = 7'h07;
            4'h8: hex7 = 7'h7F;
            4'h9: hex7 = 7'h6F;
            4'hA: hex7 = 7'h77;
            4'hB: hex7 = 7'h7C;
            4'hC: hex7 = 7'h39;
            4'hD: hex7 = 7'h5E;
            4'hE: hex7 = 7'h79;
            default: hex7 = 7'h71;
        endcase
    endfunction

    assign val_ext = VEXT_W'(out_q);
    assign cnt_ext = CEXT_W'(count_q);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            out_q      <= '0;
            count_q    <= '0;
            scan_cnt_q <= '0;
            digit_q    <= '0;
            mode_q     <= 2'd0;
            page_cnt_q <= '0;
            page_q     <= PG_VALUE;
            seg_q      <= 8'h00;
            dig_sel_q  <= '0;
        end else begin
            out_q      <= out_d;
            count_q    <= count_d;
            scan_cnt_q <= scan_cnt_d;
            digit_q    <= digit_d;
            mode_q     <= mode_d;
            page_cnt_q <= page_cnt_d;
            page_q     <= page_d;
            seg_q      <= seg_d;
            dig_sel_q  <= dig_sel_d;
        end
    end

    // Mode is resampled only at slot boundaries so a digit never changes source mid-slot.
    always_comb begin
        out_d      = bus.out_en ? bus.ar : out_q;
        count_d    = count_q;
        if (bus.cnt_clr)
            count_d = '0;
        else if (bus.ce)
            count_d = count_q + 1'b1;

        slot_end   = (scan_cnt_q == SCAN_W'(SCAN_DIV - 1));
        scan_cnt_d = slot_end ? '0 : scan_cnt_q + 1'b1;
        digit_d    = digit_q;
        mode_d     = mode_q;
        if (slot_end) begin
            mode_d  = bus.mode;
            digit_d = (digit_q == DIG_W'(DIGITS - 1)) ? '0 : digit_q + 1'b1;
        end

        page_cnt_d = '0;
        page_d     = (mode_q == 2'd1) ? PG_COUNT : PG_VALUE;
        if (mode_q == 2'd2) begin
            page_d = page_q;
            if (page_cnt_q == PAGE_W'(PAGE_DIV - 1))
                page_d = (page_q == PG_COUNT) ? PG_VALUE : PG_COUNT;
            else
                page_cnt_d = page_cnt_q + 1'b1;
        end
    end

    // Digit source: counter nibble, value nibble, or (mode 2 value page) spare slots carry
    // the counter nibbles that do not fit on the counter page.
    always_comb begin
        nib   = 4'h0;
        blank = 1'b1;
        dp    = 1'b0;
        msn   = 0;
        d_i   = int'(digit_q);
        hi_i  = DIGITS + d_i - VAL_NIB;
        for (int i = 0; i < VAL_NIB; i++) begin
            if (out_q[4*i +: 4] != 4'h0)
                msn = i;
        end
        if (page_q == PG_COUNT) begin
            if (d_i < CNT_NIB) begin
                nib   = cnt_ext[{digit_q, 2'b00} +: 4];
                blank = 1'b0;
            end
            dp = (mode_q == 2'd2) && (d_i == VAL_NIB);
        end else if (d_i < VAL_NIB) begin
            nib   = val_ext[{digit_q, 2'b00} +: 4];
            blank = (mode_q == 2'd3) && (d_i > msn);
        end else if ((mode_q == 2'd2) && (hi_i < CNT_NIB)) begin
            for (int i = 0; i < 2 * DIGITS; i++) begin
                if (i == hi_i)
                    nib = cnt_ext[4*i +: 4];
            end
            blank = 1'b0;
        end
        seg_d     = {dp, blank ? 7'h00 : hex7(nib)};
        dig_sel_d = {{(DIGITS - 1){1'b0}}, 1'b1} << digit_q;
    end

    assign bus.seg     = seg_q;
    assign bus.dig_sel = dig_sel_q;
    assign bus.page    = (page_q == PG_COUNT);
endmodule
